// File: rtl/seven_seg_dp_scanner_if.sv
// seven_seg_dp_scanner_if: digit codes and strobe in, segment/digit pins out
//   next_segment        strobe: advance the scan to the next digit
//   digits[0:3]         per-digit code: [3:0] hex, [4] DP on, [5] blank
//   segment_out         [0]=a .. [6]=g, [7]=dp
//   digit_selector_out  one-hot digit enable, bit0 = leftmost digit
//   master: register-file side, slave: scanner side
interface seven_seg_dp_scanner_if;
    logic       next_segment;
    logic [5:0] digits [0:3];
    logic [7:0] segment_out;
    logic [3:0] digit_selector_out;
    modport master (output next_segment, digits, input segment_out, digit_selector_out);
    modport slave (input next_segment, digits, output segment_out, digit_selector_out);
endinterface

// File: rtl/seven_seg_dp_scanner.sv
// seven_seg_dp_scanner: time-multiplexed 4-digit 7-segment driver with decimal points
//   clock  single clock, all state on posedge
//   reset  asynchronous, active-high; forces pins to their inactive level
//   bus    seven_seg_dp_scanner_if.slave (next_segment, digits in; segment_out, digit_selector_out out)
//   Optional macro SEVEN_SEG_GHOST_BLANK_EN: after each advance, hold all digits off
//   for BLANK_CYCLES clocks to suppress ghosting between digits.
module seven_seg_dp_scanner #(
    parameter bit SEGMENT_ACTIVE_LOW = 1'b0,
    parameter bit DIGIT_ACTIVE_LOW   = 1'b0,
    parameter int BLANK_CYCLES       = 16
) (
    input logic                   clock,
    input logic                   reset,
    seven_seg_dp_scanner_if.slave bus
);
    localparam logic [7:0] SEG_OFF = SEGMENT_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [3:0] DIG_OFF = DIGIT_ACTIVE_LOW ? 4'hF : 4'h0;
    logic [1:0] idx;
    logic [5:0] cur;
    logic [7:0] seg;
    always_comb begin
        cur = bus.digits[idx];
        seg = 8'h00;
        // blank bit folded into the selector so blank and unknown codes both land on default
        case ({cur[5], cur[3:0]})
            5'h00: seg[6:0] = 7'h3F;
            5'h01: seg[6:0] = 7'h06;
            5'h02: seg[6:0] = 7'h5B;
            5'h03: seg[6:0] = 7'h4F;
            5'h04: seg[6:0] = 7'h66;
            5'h05: seg[6:0] = 7'h6D;
            5'h06: seg[6:0] = 7'h7D;
            5'h07: seg[6:0] = 7'h07;
            5'h08: seg[6:0] = 7'h7F;
            5'h09: seg[6:0] = 7'h6F;
            5'h0A: seg[6:0] = 7'h77;
            5'h0B: seg[6:0] = 7'h7C;
            5'h0C: seg[6:0] = 7'h39;
            5'h0D: seg[6:0] = 7'h5E;
            5'h0E: seg[6:0] = 7'h79;
            5'h0F: seg[6:0] = 7'h71;
            default: seg[6:0] = 7'h00;
        endcase
        if (cur[5:4] == 2'b01) seg[7] = 1'b1;
    end
`ifdef SEVEN_SEG_GHOST_BLANK_EN
    localparam int CW = $clog2(BLANK_CYCLES + 1);
    logic [CW-1:0] blank_cnt;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx                    <= 2'd0;
            blank_cnt              <= '0;
            bus.segment_out        <= SEG_OFF;
            bus.digit_selector_out <= DIG_OFF;
        end else begin
            idx                    <= idx + {1'b0, bus.next_segment};
            blank_cnt              <= bus.next_segment ? CW'(BLANK_CYCLES) : (blank_cnt != '0) ? blank_cnt - 1'b1 : blank_cnt;
            bus.segment_out        <= (blank_cnt != '0) ? SEG_OFF : seg ^ SEG_OFF;
            bus.digit_selector_out <= (blank_cnt != '0) ? DIG_OFF : (4'b0001 << idx) ^ DIG_OFF;
        end
    end
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx                    <= 2'd0;
            bus.segment_out        <= SEG_OFF;
            bus.digit_selector_out <= DIG_OFF;
        end else begin
            idx                    <= idx + {1'b0, bus.next_segment};
            bus.segment_out        <= seg ^ SEG_OFF;
            bus.digit_selector_out <= (4'b0001 << idx) ^ DIG_OFF;
        end
    end
`endif
endmodule

// File: tb/tb_seven_seg_dp_scanner.sv
// tb_seven_seg_dp_scanner: directed scoreboard bench for seven_seg_dp_scanner
module tb_seven_seg_dp_scanner;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;
    seven_seg_dp_scanner_if bus ();
    seven_seg_dp_scanner_if bus_low ();
    seven_seg_dp_scanner dut (.clock(clock), .reset(reset), .bus(bus));
    seven_seg_dp_scanner #(.SEGMENT_ACTIVE_LOW(1'b1)) dut_low (.clock(clock), .reset(reset), .bus(bus_low));
    always #5 clock = ~clock;
    typedef struct {
        logic [7:0] seg;
        logic [3:0] sel;
    } exp_t;
    exp_t sb [$];
    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [1:0] m_idx = 2'd0;
    function automatic logic [7:0] model_seg(logic [5:0] c);
        if ($isunknown(c) || c[5]) return 8'h00;
        return {c[4], hex_tab[c[3:0]]};
    endfunction
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask
    task automatic step(string tag, logic strobe);
        exp_t e;
        exp_t got;
        bus.next_segment = strobe;
        e.seg = model_seg(bus.digits[m_idx]);
        e.sel = 4'b0001 << m_idx;
        sb.push_back(e);
        if (strobe) m_idx = m_idx + 2'd1;
        @(posedge clock);
        #1;
        got = sb.pop_front();
        chk({tag, "_seg"}, 32'(bus.segment_out), 32'(got.seg));
        chk({tag, "_sel"}, 32'(bus.digit_selector_out), 32'(got.sel));
        chk({tag, "_onehot"}, 32'($onehot(bus.digit_selector_out)), 32'd1);
        @(negedge clock);
        bus.next_segment = 1'b0;
    endtask
    initial begin
        bus.next_segment = 1'b0;
        bus_low.next_segment = 1'b0;
        bus.digits = '{6'h05, 6'h00, 6'h00, 6'h00};
        bus_low.digits = '{6'h18, 6'h18, 6'h18, 6'h18};
        #2 reset = 1'b1;
        #1;
        chk("rst_seg", 32'(bus.segment_out), 32'h00);
        chk("rst_sel", 32'(bus.digit_selector_out), 32'h0);
        chk("rst_low_seg", 32'(bus_low.segment_out), 32'hFF);
        chk("rst_low_sel", 32'(bus_low.digit_selector_out), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        m_idx = 2'd0;
        step("dec05", 1'b0);
        chk("low_lit_seg", 32'(bus_low.segment_out), 32'h00);
        chk("low_lit_sel", 32'(bus_low.digit_selector_out), 32'h1);
        bus.digits[0] = 6'h18;
        step("dec18", 1'b0);
        bus.digits[0] = 6'h2F;
        step("dec2F", 1'b0);
        bus.digits = '{6'h01, 6'h02, 6'h03, 6'h04};
        step("scan_base", 1'b0);
        for (int i = 0; i < 4; i++) begin
            step("scan_strobe", 1'b1);
            step("scan_show", 1'b0);
        end
        for (int i = 0; i < 6; i++) step("held", 1'b1);
        step("held_end", 1'b0);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_seg", 32'(bus.segment_out), 32'h00);
        chk("mid_rst_sel", 32'(bus.digit_selector_out), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        m_idx = 2'd0;
        step("after_rst", 1'b0);
        bus.digits[0] = 6'bxxxxxx;
        step("unknown", 1'b0);
        bus.digits[0] = 6'h1A;
        step("decA_dp", 1'b0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
